// File: rtl/cache_wb_nway_if.sv
// CPU-side and memory-side buses of the write-back N-way cache.
// slave = the cache; master = the CPU pipeline plus the block memory that surround it.
interface cache_wb_nway_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned WORDS  = 4
);
  logic                  cpu_req;
  logic                  cpu_we;
  logic [ADDR_W-1:0]     cpu_addr;
  logic [31:0]           cpu_wdata;
  logic [31:0]           cpu_rdata;
  logic                  cpu_ready;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [32*WORDS-1:0]   mem_wdata;
  logic [32*WORDS-1:0]   mem_rdata;
  logic                  mem_ack;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    output cpu_rdata, cpu_ready, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    input  cpu_rdata, cpu_ready, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_wb_nway.sv
// N-way set-associative write-back / write-allocate data cache with true LRU and a req/ack refill FSM.
// Optional CACHE_STATS_EN adds saturating hit/miss/write-back counters.
module cache_wb_nway #(
  parameter int unsigned WAYS   = 2,
  parameter int unsigned SETS   = 1024,
  parameter int unsigned WORDS  = 4,
  parameter int unsigned ADDR_W = 32
) (
  input  logic clk,
  input  logic reset,
  cache_wb_nway_if.slave bus
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_misses,
  output logic [31:0] stat_wbacks
`endif
);

  localparam int unsigned WORD_W = $clog2(WORDS);
  localparam int unsigned OFF_W  = WORD_W + 2;
  localparam int unsigned SET_W  = $clog2(SETS);
  localparam int unsigned TAG_W  = ADDR_W - SET_W - OFF_W;
  localparam int unsigned BLK_W  = ADDR_W - OFF_W;
  localparam int unsigned WIX_W  = (WORDS > 1) ? WORD_W : 1;
  localparam int unsigned SIX_W  = (SETS > 1) ? SET_W : 1;
  localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned AGE_W  = WAY_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WB   = 2'd1;
  localparam logic [1:0] S_FILL = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [BLK_W-1:0]  mblk_q;
  logic [WAY_W-1:0]  vict_q;

  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];
  logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
  logic [31:0]       data_q  [WAYS][SETS][WORDS];

  logic [TAG_W-1:0]  req_tag, miss_tag, vict_tag;
  logic [SIX_W-1:0]  req_set, miss_set;
  logic [WIX_W-1:0]  req_word;
  logic [WAYS-1:0]   hit_vec;
  logic [WAY_W-1:0]  hit_way, lru_way, victim;
  logic              hit, hit_upd, store_upd, miss_start, fill_done, wb_needed, found;
  logic [BLK_W-1:0]  out_blk;

  // Address decomposition for the live request and the latched miss
  assign req_tag  = bus.cpu_addr[ADDR_W-1 -: TAG_W];
  assign req_set  = (SETS > 1) ? bus.cpu_addr[OFF_W +: SIX_W] : '0;
  assign req_word = (WORDS > 1) ? bus.cpu_addr[2 +: WIX_W] : '0;
  assign miss_tag = mblk_q[BLK_W-1 -: TAG_W];
  assign miss_set = (SETS > 1) ? mblk_q[SIX_W-1:0] : '0;

  // Tag match across all ways of the addressed set
  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[req_set][w] && (tag_q[w][req_set] == req_tag)) begin
        hit_vec[w] = 1'b1;
        hit_way    = WAY_W'(w);
      end
    end
  end

  assign hit       = bus.cpu_req && (|hit_vec);
  assign hit_upd   = (state_q == S_IDLE) && hit;
  assign store_upd = hit_upd && bus.cpu_we;
  assign fill_done = (state_q == S_FILL) && bus.mem_ack;

  assign bus.cpu_ready = (state_q == S_IDLE) && (!bus.cpu_req || hit);
  assign bus.cpu_rdata = data_q[hit_way][req_set][req_word];

  // True LRU ages; a direct-mapped cache has no replacement state
  if (WAYS > 1) begin : g_lru
    logic [AGE_W-1:0] age_q [SETS][WAYS];
    logic [AGE_W-1:0] hit_age;

    assign hit_age = age_q[req_set][hit_way];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int unsigned s = 0; s < SETS; s++)
          for (int unsigned w = 0; w < WAYS; w++)
            age_q[s][w] <= AGE_W'(w);
      end else if (hit_upd) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == hit_way)
            age_q[req_set][w] <= '0;
          else if (age_q[req_set][w] < hit_age)
            age_q[req_set][w] <= age_q[req_set][w] + 1'b1;
        end
      end
    end

    always_comb begin
      lru_way = '0;
      for (int unsigned w = 0; w < WAYS; w++)
        if (age_q[req_set][w] == AGE_W'(WAYS - 1))
          lru_way = WAY_W'(w);
    end
  end else begin : g_dm
    assign lru_way = '0;
  end

  // Victim: lowest invalid way first, otherwise the LRU way
  always_comb begin
    victim = lru_way;
    found  = 1'b0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!found && !valid_q[req_set][w]) begin
        victim = WAY_W'(w);
        found  = 1'b1;
      end
    end
  end

  assign wb_needed = valid_q[req_set][victim] && dirty_q[req_set][victim];

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    miss_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.cpu_req && !hit) begin
          miss_start = 1'b1;
          state_d    = wb_needed ? S_WB : S_FILL;
        end
      end
      S_WB:    if (bus.mem_ack) state_d = S_FILL;
      S_FILL:  if (bus.mem_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      mblk_q  <= '0;
      vict_q  <= '0;
    end else begin
      state_q <= state_d;
      if (miss_start) begin
        mblk_q <= bus.cpu_addr[ADDR_W-1:OFF_W];
        vict_q <= victim;
      end
    end
  end

  // Memory-side outputs are decoded from registered state, so they hold until mem_ack
  assign vict_tag = tag_q[vict_q][miss_set];

  always_comb begin
    out_blk = mblk_q;
    if (state_q == S_WB)
      out_blk[BLK_W-1 -: TAG_W] = vict_tag;
  end

  assign bus.mem_req  = (state_q != S_IDLE);
  assign bus.mem_we   = (state_q == S_WB);
  assign bus.mem_addr = {out_blk, {OFF_W{1'b0}}};

  always_comb begin
    bus.mem_wdata = '0;
    for (int unsigned i = 0; i < WORDS; i++)
      bus.mem_wdata[32*i +: 32] = data_q[vict_q][miss_set][i];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else begin
      if (fill_done) begin
        valid_q[miss_set][vict_q] <= 1'b1;
        dirty_q[miss_set][vict_q] <= 1'b0;
      end
      if (store_upd)
        dirty_q[req_set][hit_way] <= 1'b1;
    end
  end

  // Tag/data arrays carry no reset; valid bits qualify them
  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_q[vict_q][miss_set] <= miss_tag;
      for (int unsigned i = 0; i < WORDS; i++)
        data_q[vict_q][miss_set][i] <= bus.mem_rdata[32*i +: 32];
    end else if (store_upd) begin
      data_q[hit_way][req_set][req_word] <= bus.cpu_wdata;
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_hits   <= '0;
      stat_misses <= '0;
      stat_wbacks <= '0;
    end else begin
      if (hit_upd && (stat_hits != 32'hFFFF_FFFF))
        stat_hits <= stat_hits + 32'd1;
      if (miss_start && (stat_misses != 32'hFFFF_FFFF))
        stat_misses <= stat_misses + 32'd1;
      if (miss_start && (state_d == S_WB) && (stat_wbacks != 32'hFFFF_FFFF))
        stat_wbacks <= stat_wbacks + 32'd1;
    end
  end
`else
  // Statistics hardware is not built in this configuration
`endif

endmodule
